cache_ctrl_fsm: RTL and testbench

- Controller for the 2-way, 64-set, 8-byte-line cache datapath: tag compare, way mux, 64-bit line storage and byte select.
- Owns the tag, valid and LRU state, and sequences lookup, read-miss refill, write-through with write-invalidate, and flush.
- Drives the datapath's index, way and line-write enable, and a single-outstanding memory request handshake.
- Sits between the VLIW load/store unit and the memory interface.

---
 rtl/cache_ctrl_fsm_if.sv | 37 +++
 rtl/cache_ctrl_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_fsm_if.sv
// rtl/cache_ctrl_fsm_if.sv - CPU, data-array and memory signal bundle for the cache controller
interface cache_ctrl_fsm_if #(
  parameter int IDX_W  = 6,
  parameter int OFF_W  = 3,
  parameter int DATA_W = 64
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              flush;
  logic              cpu_ready;
  logic              cpu_hit;
  logic [IDX_W-1:0]  arr_index;
  logic              arr_way;
  logic [OFF_W-1:0]  arr_offset;
  logic              arr_we;
  logic [DATA_W-1:0] arr_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
    output cpu_ready, cpu_hit, arr_index, arr_way, arr_offset, arr_we, arr_wdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
    input  cpu_ready, cpu_hit, arr_index, arr_way, arr_offset, arr_we, arr_wdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - 2-way set-associative cache controller: lookup, refill, write-through, flush
module cache_ctrl_fsm #(
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 6,
  parameter int OFF_W  = 3,
  parameter int DATA_W = 64
) (
  input  logic           clk,
  input  logic           reset,
  cache_ctrl_fsm_if.master bus
);
  localparam int SETS = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_RD, S_FILL, S_MEM_WR, S_FLUSH, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [31:0]       r_addr;
  logic              r_we;
  logic [7:0]        r_wdata;
  logic              r_hit;
  logic              r_way;
  logic [DATA_W-1:0] r_arr_wdata;

  logic [TAG_W-1:0]  r_tag   [SETS][2];
  logic [1:0]        r_valid [SETS];
  logic [SETS-1:0]   r_lru;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [OFF_W-1:0]  w_off;
  logic              w_hit0;
  logic              w_hit1;
  logic              w_hit;
  logic              w_hit_way;
  logic              w_victim;

  assign w_idx  = r_addr[OFF_W +: IDX_W];
  assign w_tag  = r_addr[31 -: TAG_W];
  assign w_off  = r_addr[OFF_W-1:0];
  assign w_hit0 = r_valid[w_idx][0] && (r_tag[w_idx][0] == w_tag);
  assign w_hit1 = r_valid[w_idx][1] && (r_tag[w_idx][1] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;
  // Way 0 takes priority when both ways match.
  assign w_hit_way = ~w_hit0;
  assign w_victim  = !r_valid[w_idx][0] ? 1'b0 :
                     !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.flush) begin
          w_next = S_FLUSH;
        end else if (bus.cpu_req) begin
          w_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (r_we) begin
          w_next = S_MEM_WR;
        end else if (w_hit) begin
          w_next = S_DONE;
        end else begin
          w_next = S_MEM_RD;
        end
      end
      S_MEM_RD: if (bus.mem_ack) w_next = S_FILL;
      S_FILL:   w_next = S_DONE;
      S_MEM_WR: if (bus.mem_ack) w_next = S_DONE;
      S_FLUSH:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_hit       <= 1'b0;
      r_way       <= 1'b0;
      r_arr_wdata <= '0;
      r_lru       <= '0;
      for (int i = 0; i < SETS; i++) begin
        r_valid[i] <= 2'b00;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.flush && bus.cpu_req) begin
            r_addr  <= bus.cpu_addr;
            r_we    <= bus.cpu_we;
            r_wdata <= bus.cpu_wdata;
          end
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          if (r_we) begin
            r_way <= w_hit_way;
            // Write-invalidate: stores never allocate and drop a matching line.
            if (w_hit) begin
              r_valid[w_idx][w_hit_way] <= 1'b0;
            end
          end else if (w_hit) begin
            r_way        <= w_hit_way;
            r_lru[w_idx] <= ~w_hit_way;
          end else begin
            r_way <= w_victim;
          end
        end
        S_MEM_RD: begin
          if (bus.mem_ack) begin
            r_arr_wdata <= bus.mem_rdata;
          end
        end
        S_FILL: begin
          r_valid[w_idx][r_way] <= 1'b1;
          r_lru[w_idx]          <= ~r_way;
        end
        S_FLUSH: begin
          r_hit <= 1'b0;
          for (int i = 0; i < SETS; i++) begin
            r_valid[i] <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  // Tags need no reset: a line is only consulted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_FILL) begin
      r_tag[w_idx][r_way] <= w_tag;
    end
  end

  always_comb begin
    bus.cpu_ready  = 1'b0;
    bus.cpu_hit    = 1'b0;
    bus.arr_index  = '0;
    bus.arr_way    = 1'b0;
    bus.arr_offset = '0;
    bus.arr_we     = 1'b0;
    bus.arr_wdata  = r_arr_wdata;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (r_state)
      S_LOOKUP: begin
        bus.arr_index  = w_idx;
        bus.arr_offset = w_off;
        bus.arr_way    = w_hit ? w_hit_way : w_victim;
      end
      S_MEM_RD: begin
        bus.arr_index  = w_idx;
        bus.arr_offset = w_off;
        bus.arr_way    = r_way;
        bus.mem_req    = 1'b1;
        bus.mem_addr   = {r_addr[31:OFF_W], {OFF_W{1'b0}}};
      end
      S_FILL: begin
        bus.arr_index  = w_idx;
        bus.arr_offset = w_off;
        bus.arr_way    = r_way;
        bus.arr_we     = 1'b1;
      end
      S_MEM_WR: begin
        bus.arr_index  = w_idx;
        bus.arr_offset = w_off;
        bus.arr_way    = r_way;
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = r_addr;
        bus.mem_wdata  = r_wdata;
      end
      S_DONE: begin
        bus.cpu_ready  = 1'b1;
        bus.cpu_hit    = r_hit;
        bus.arr_index  = w_idx;
        bus.arr_offset = w_off;
        bus.arr_way    = r_way;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb/tb_cache_ctrl_fsm.sv - randomized self-checking bench for cache_ctrl_fsm against a set/way model
module tb_cache_ctrl_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_ctrl_fsm_if bus();
  cache_ctrl_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;

  // Reference cache: per set two (valid, tag) entries and the way to evict next.
  bit          m_valid [64][2];
  logic [22:0] m_tag   [64][2];
  bit          m_lru   [64];

  function automatic void model_clear(input bit keep_lru);
    for (int s = 0; s < 64; s++) begin
      m_valid[s][0] = 0;
      m_valid[s][1] = 0;
      if (!keep_lru) m_lru[s] = 0;
    end
  endfunction

  function automatic void model_access(input bit we, input logic [31:0] a, output bit hit, output bit way);
    int s;
    logic [22:0] t;
    bit h0, h1;
    s = int'(a[8:3]);
    t = a[31:9];
    h0 = m_valid[s][0] && m_tag[s][0] == t;
    h1 = m_valid[s][1] && m_tag[s][1] == t;
    hit = h0 || h1;
    way = h0 ? 1'b0 : 1'b1;
    if (we) begin
      if (hit) m_valid[s][way] = 0;
    end else if (hit) begin
      m_lru[s] = !way;
    end else begin
      way = !m_valid[s][0] ? 1'b0 : (!m_valid[s][1] ? 1'b1 : m_lru[s]);
      m_valid[s][way] = 1;
      m_tag[s][way] = t;
      m_lru[s] = !way;
    end
  endfunction

  logic        o_timeout, o_hit, o_way, o_mem_seen, o_mem_we, o_req_after_ack, o_mem_unstable;
  logic        o_flush_done, o_flush_hit, o_flush_mem, o_fill_way;
  logic [5:0]  o_index, o_fill_index;
  logic [2:0]  o_offset;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [63:0] o_fill_wdata;
  int          o_ready_cyc, o_ack_cyc, o_fill_cnt;

  // Drives one CPU access (optionally with a flush in the same IDLE cycle) and plays the memory side.
  task automatic run_access(input bit we, input logic [31:0] a, input logic [7:0] wd,
                            input logic [63:0] rd, input int dly, input bit with_flush);
    int cyc, mcount;
    bit done;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd; bus.flush = with_flush;
    o_timeout = 0; o_hit = 0; o_way = 0; o_mem_seen = 0; o_mem_we = 0; o_req_after_ack = 0;
    o_mem_unstable = 0; o_flush_done = 0; o_flush_hit = 0; o_flush_mem = 0; o_fill_way = 0;
    o_index = 0; o_fill_index = 0; o_offset = 0; o_mem_addr = 0; o_mem_wdata = 0; o_fill_wdata = 0;
    o_ready_cyc = -1; o_ack_cyc = -100; o_fill_cnt = 0;
    cyc = 0; mcount = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      cyc++;
      bus.flush = 1'b0;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        if (bus.mem_req) o_req_after_ack = 1;
      end
      bus.mem_rdata = {$urandom, $urandom};
      if (bus.arr_we) begin
        o_fill_cnt++; o_fill_index = bus.arr_index; o_fill_way = bus.arr_way; o_fill_wdata = bus.arr_wdata;
      end
      if (bus.mem_req && !o_req_after_ack) begin
        if (!o_mem_seen) begin
          o_mem_we = bus.mem_we; o_mem_addr = bus.mem_addr; o_mem_wdata = bus.mem_wdata;
        end else if (bus.mem_we !== o_mem_we || bus.mem_addr !== o_mem_addr || bus.mem_wdata !== o_mem_wdata) begin
          o_mem_unstable = 1;
        end
        o_mem_seen = 1;
        mcount++;
        if (mcount > dly) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = rd; o_ack_cyc = cyc;
        end
      end
      if (bus.cpu_ready) begin
        if (with_flush && !o_flush_done) begin
          o_flush_done = 1; o_flush_hit = bus.cpu_hit; o_flush_mem = o_mem_seen; cyc = -1;
        end else begin
          o_ready_cyc = cyc; o_hit = bus.cpu_hit; o_way = bus.arr_way;
          o_index = bus.arr_index; o_offset = bus.arr_offset;
          bus.cpu_req = 1'b0; done = 1;
        end
      end
    end
    o_timeout = !done;
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.flush = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready got=%0h exp=0", bus.cpu_ready); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%0h exp=0", bus.mem_req); end
    n_checks++; if (bus.arr_we !== 1'b0) begin n_fail++; $display("FAIL reset_arr_we got=%0h exp=0", bus.arr_we); end
    n_checks++; if (bus.arr_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_arr_wdata got=%0h exp=0", bus.arr_wdata); end
    n_checks++; if ({bus.arr_index, bus.arr_way, bus.arr_offset, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.cpu_hit} !== '0) begin
      n_fail++; $display("FAIL reset_outputs index=%0h way=%0h off=%0h maddr=%0h", bus.arr_index, bus.arr_way, bus.arr_offset, bus.mem_addr);
    end
    reset = 1'b0;
    model_clear(0);
  endtask

  task automatic test_miss_fill();
    bit h, w;
    model_access(0, 32'h0000123C, h, w);
    run_access(0, 32'h0000123C, 8'h00, 64'h1122334455667788, 0, 0);
    n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL miss_timeout got=%0h exp=0", o_timeout); end
    n_checks++; if (o_mem_addr !== 32'h00001238 || o_mem_we !== 1'b0) begin n_fail++; $display("FAIL miss_mem_req addr=%0h we=%0h exp addr=1238 we=0", o_mem_addr, o_mem_we); end
    n_checks++; if (o_fill_cnt !== 1 || o_fill_index !== 6'd7 || o_fill_way !== 1'b0) begin
      n_fail++; $display("FAIL miss_fill cnt=%0d idx=%0d way=%0h exp 1/7/0", o_fill_cnt, o_fill_index, o_fill_way);
    end
    n_checks++; if (o_fill_wdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL miss_fill_data got=%0h exp=1122334455667788", o_fill_wdata); end
    n_checks++; if (o_hit !== 1'b0 || o_ready_cyc !== o_ack_cyc + 2) begin
      n_fail++; $display("FAIL miss_done hit=%0h ready=%0d ack=%0d exp hit=0 ready=ack+2", o_hit, o_ready_cyc, o_ack_cyc);
    end
    n_checks++; if (o_req_after_ack !== 1'b0) begin n_fail++; $display("FAIL miss_req_drop got=%0h exp=0", o_req_after_ack); end
  endtask

  task automatic test_hit();
    bit h, w;
    model_access(0, 32'h0000123C, h, w);
    run_access(0, 32'h0000123C, 8'h00, 64'h0, 0, 0);
    n_checks++; if (o_mem_seen !== 1'b0 || o_fill_cnt !== 0) begin n_fail++; $display("FAIL hit_no_mem mem=%0h fills=%0d exp 0/0", o_mem_seen, o_fill_cnt); end
    n_checks++; if (o_ready_cyc !== 2) begin n_fail++; $display("FAIL hit_latency got=%0d exp=2", o_ready_cyc); end
    n_checks++; if (o_hit !== 1'b1 || o_way !== 1'b0 || o_offset !== 3'd4 || o_index !== 6'd7) begin
      n_fail++; $display("FAIL hit_done hit=%0h way=%0h off=%0d idx=%0d exp 1/0/4/7", o_hit, o_way, o_offset, o_index);
    end
  endtask

  task automatic test_lru();
    bit h, w;
    logic [31:0] addrs [3] = '{32'h0000143C, 32'h0000163C, 32'h0000123C};
    bit          ways  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      model_access(0, addrs[i], h, w);
      run_access(0, addrs[i], 8'h00, {$urandom, $urandom}, i, 0);
      n_checks++; if (o_hit !== 1'b0 || o_fill_cnt !== 1 || o_fill_way !== ways[i] || w !== ways[i]) begin
        n_fail++; $display("FAIL lru_victim_%0d hit=%0h fills=%0d way=%0h exp hit=0 way=%0h", i, o_hit, o_fill_cnt, o_fill_way, ways[i]);
      end
    end
  endtask

  task automatic test_store();
    bit h, w;
    model_access(0, 32'h0000143C, h, w);
    run_access(0, 32'h0000143C, 8'h00, {$urandom, $urandom}, 1, 0);
    model_access(1, 32'h0000143C, h, w);
    run_access(1, 32'h0000143C, 8'hAB, 64'h0, 2, 0);
    n_checks++; if (o_mem_we !== 1'b1 || o_mem_addr !== 32'h0000143C || o_mem_wdata !== 8'hAB) begin
      n_fail++; $display("FAIL store_mem we=%0h addr=%0h data=%0h exp 1/143C/AB", o_mem_we, o_mem_addr, o_mem_wdata);
    end
    n_checks++; if (o_hit !== 1'b1 || h !== 1'b1 || o_ready_cyc !== o_ack_cyc + 1 || o_fill_cnt !== 0) begin
      n_fail++; $display("FAIL store_done hit=%0h ready=%0d ack=%0d fills=%0d exp hit=1 ready=ack+1 fills=0", o_hit, o_ready_cyc, o_ack_cyc, o_fill_cnt);
    end
    n_checks++; if (o_mem_unstable !== 1'b0) begin n_fail++; $display("FAIL store_mem_stable got=%0h exp=0", o_mem_unstable); end
    model_access(0, 32'h0000143C, h, w);
    run_access(0, 32'h0000143C, 8'h00, {$urandom, $urandom}, 0, 0);
    n_checks++; if (o_hit !== 1'b0 || o_fill_cnt !== 1) begin n_fail++; $display("FAIL store_invalidate hit=%0h fills=%0d exp 0/1", o_hit, o_fill_cnt); end
  endtask

  task automatic test_flush();
    bit h, w;
    model_clear(1);
    model_access(0, 32'h0000123C, h, w);
    run_access(0, 32'h0000123C, 8'h00, {$urandom, $urandom}, 0, 1);
    n_checks++; if (o_flush_done !== 1'b1 || o_flush_hit !== 1'b0 || o_flush_mem !== 1'b0) begin
      n_fail++; $display("FAIL flush_done done=%0h hit=%0h mem=%0h exp 1/0/0", o_flush_done, o_flush_hit, o_flush_mem);
    end
    n_checks++; if (o_timeout !== 1'b0 || o_hit !== 1'b0 || o_mem_seen !== 1'b1 || o_fill_cnt !== 1 || o_fill_way !== w) begin
      n_fail++; $display("FAIL flush_then_miss to=%0h hit=%0h mem=%0h fills=%0d way=%0h exp 0/0/1/1/%0h", o_timeout, o_hit, o_mem_seen, o_fill_cnt, o_fill_way, w);
    end
  endtask

  task automatic test_reset_midflight();
    bit seen, h, w;
    int stray;
    seen = 0; stray = 0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h00ABC010;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.mem_req) seen = 1;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midflight_mem_req got=%0h exp=1", seen); end
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b0) begin
      n_fail++; $display("FAIL midflight_abandon mem_req=%0h ready=%0h exp 0/0", bus.mem_req, bus.cpu_ready);
    end
    reset = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.arr_we || bus.cpu_ready || bus.mem_req) stray++;
      @(negedge clk);
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL midflight_stray_ack got=%0d exp=0", stray); end
    model_clear(0);
    model_access(0, 32'h0000123C, h, w);
    run_access(0, 32'h0000123C, 8'h00, {$urandom, $urandom}, 0, 0);
    n_checks++; if (o_hit !== 1'b0 || o_fill_cnt !== 1 || o_fill_way !== 1'b0) begin
      n_fail++; $display("FAIL midflight_valid_clear hit=%0h fills=%0d way=%0h exp 0/1/0", o_hit, o_fill_cnt, o_fill_way);
    end
  endtask

  task automatic test_random();
    bit h, w, we, fl;
    logic [31:0] a;
    logic [7:0] wd;
    logic [63:0] rd;
    logic [5:0] s;
    int dly;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: s = 6'd0;
        1: s = 6'd7;
        default: s = 6'd63;
      endcase
      a = {23'($urandom_range(0, 3)) ^ ($urandom_range(0, 1) ? 23'h400000 : 23'h0), s, 3'($urandom)};
      we = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      wd = 8'($urandom);
      rd = {$urandom, $urandom};
      dly = $urandom_range(0, 3);
      if (fl) model_clear(1);
      model_access(we, a, h, w);
      run_access(we, a, wd, rd, dly, fl);
      n_checks++; if (o_timeout !== 1'b0 || o_hit !== h) begin
        n_fail++; $display("FAIL rnd_%0d_hit addr=%0h we=%0h got=%0h exp=%0h timeout=%0h", i, a, we, o_hit, h, o_timeout);
      end
      if (fl) begin
        n_checks++; if (o_flush_done !== 1'b1 || o_flush_hit !== 1'b0) begin
          n_fail++; $display("FAIL rnd_%0d_flush done=%0h hit=%0h exp 1/0", i, o_flush_done, o_flush_hit);
        end
      end
      if (we) begin
        n_checks++; if (o_mem_we !== 1'b1 || o_mem_addr !== a || o_mem_wdata !== wd || o_ready_cyc !== o_ack_cyc + 1 || o_fill_cnt !== 0) begin
          n_fail++; $display("FAIL rnd_%0d_store we=%0h addr=%0h data=%0h ready=%0d ack=%0d fills=%0d exp addr=%0h data=%0h", i, o_mem_we, o_mem_addr, o_mem_wdata, o_ready_cyc, o_ack_cyc, o_fill_cnt, a, wd);
        end
      end else if (h) begin
        n_checks++; if (o_mem_seen !== 1'b0 || o_ready_cyc !== 2 || o_way !== w || o_index !== s || o_offset !== a[2:0] || o_fill_cnt !== 0) begin
          n_fail++; $display("FAIL rnd_%0d_hit_done mem=%0h ready=%0d way=%0h idx=%0d off=%0d exp way=%0h idx=%0d off=%0d", i, o_mem_seen, o_ready_cyc, o_way, o_index, o_offset, w, s, a[2:0]);
        end
      end else begin
        n_checks++; if (o_mem_we !== 1'b0 || o_mem_addr !== {a[31:3], 3'b000} || o_fill_cnt !== 1 || o_fill_way !== w || o_fill_index !== s || o_fill_wdata !== rd || o_ready_cyc !== o_ack_cyc + 2) begin
          n_fail++; $display("FAIL rnd_%0d_miss addr=%0h way=%0h idx=%0d data=%0h ready=%0d ack=%0d exp way=%0h idx=%0d data=%0h", i, o_mem_addr, o_fill_way, o_fill_index, o_fill_wdata, o_ready_cyc, o_ack_cyc, w, s, rd);
        end
      end
      if (we || !h) begin
        n_checks++; if (o_mem_unstable !== 1'b0 || o_req_after_ack !== 1'b0) begin
          n_fail++; $display("FAIL rnd_%0d_mem_hs unstable=%0h req_after_ack=%0h exp 0/0", i, o_mem_unstable, o_req_after_ack);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_lru();
    test_store();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
